// File: rtl/gray_pkg.sv
// gray_pkg: shared code width and requester ids for the Gray-code arbiter
package gray_pkg;
    localparam int GW = 4;
    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;
endpackage

// File: rtl/binary_to_gray.sv
// binary_to_gray: combinational 4-bit binary to Gray code converter
module binary_to_gray (
    input  logic [3:0] b,
    output logic [3:0] g
);
    assign g = b ^ (b >> 1);
endmodule

// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: round-robin sharing of one binary_to_gray converter between two requesters
module gray_conv_arbiter
    import gray_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [GW-1:0] req0_bin,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [GW-1:0] req1_bin,
    output logic          req1_ready,
    output logic          out_valid,
    output logic [GW-1:0] out_gray,
    output logic          out_id,
    input  logic          out_ready,
    output logic [CW-1:0] grant_cnt0,
    output logic [CW-1:0] grant_cnt1
);
    logic          can_load, grant0, grant1, last_grant;
    logic [GW-1:0] sel_bin, sel_gray;

    // Under contention the requester that did not win last time gets the grant
    assign can_load   = ~out_valid | out_ready;
    assign grant0     = req0_valid & (~req1_valid | last_grant == ID_REQ1);
    assign grant1     = req1_valid & (~req0_valid | last_grant == ID_REQ0);
    assign req0_ready = grant0 & can_load;
    assign req1_ready = grant1 & can_load;
    assign sel_bin    = grant1 ? req1_bin : req0_bin;

    binary_to_gray u_b2g (
        .b(sel_bin),
        .g(sel_gray)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_gray   <= '0;
            out_id     <= ID_REQ0;
            last_grant <= ID_REQ1;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (req0_ready | req1_ready) begin
                out_valid  <= 1'b1;
                out_gray   <= sel_gray;
                out_id     <= req1_ready ? ID_REQ1 : ID_REQ0;
                last_grant <= req1_ready ? ID_REQ1 : ID_REQ0;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (req0_ready) grant_cnt0 <= grant_cnt0 + CW'(1);
            if (req1_ready) grant_cnt1 <= grant_cnt1 + CW'(1);
        end
    end
endmodule

// File: doc/gray_conv_arbiter.md
# gray_conv_arbiter

Round-robin arbiter that shares a single 4-bit `binary_to_gray` converter between two requesters. Each requester offers a binary code with a valid/ready handshake. The winner's code is converted, registered and presented on one output port tagged with the requester id. Per-requester grant counters are provided for debug and throughput checks.

## Interface

Parameters:
- `CW`, default 8: width of each grant counter.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req0_valid` input 1: requester 0 offers `req0_bin`.
- `req0_bin` input 4: requester 0 binary code.
- `req0_ready` output 1: requester 0 transfer accepted this cycle.
- `req1_valid` input 1: requester 1 offers `req1_bin`.
- `req1_bin` input 4: requester 1 binary code.
- `req1_ready` output 1: requester 1 transfer accepted this cycle.
- `out_valid` output 1: `out_gray` and `out_id` are valid.
- `out_gray` output 4: converted Gray code.
- `out_id` output 1: source of `out_gray` (0 or 1).
- `out_ready` input 1: consumer accepts the output.
- `grant_cnt0` output CW: number of accepted req0 transfers, modulo 2^CW.
- `grant_cnt1` output CW: number of accepted req1 transfers, modulo 2^CW.

## Operation

**Output register**
- One entry. `EMPTY` when `out_valid=0`, `FULL` when `out_valid=1`.
- `can_load = ~out_valid | out_ready`.

**Arbitration (combinational each cycle)**
- Only req0 valid: grant 0. Only req1 valid: grant 1.
- Both valid: grant the requester that is not `last_grant`.
- Neither valid: no grant.

**Handshake**
- `reqN_ready = grantN & can_load`. At most one ready is high per cycle.
- A transfer occurs when `reqN_valid & reqN_ready`.
- Requesters hold valid and data stable until ready. The arbiter does not depend on this, because it re-arbitrates every cycle.

**On a transfer**
- `out_gray <= bin ^ (bin >> 1)`, taken from the `binary_to_gray` instance.
- `out_id <= N`, `out_valid <= 1`.
- `last_grant <= N`.
- `grant_cntN <= grant_cntN + 1`, wrapping from 2^CW-1 to 0.

**Without a transfer**
- If `out_valid & out_ready`: `out_valid <= 0`.
- Otherwise the output register holds, and `last_grant` and the counters hold.

**Edge cases**
- Simultaneous drain and load (FULL, `out_ready=1`, a request valid): the new entry loads in the same cycle, so `out_valid` stays 1 with no bubble.
- Output stalled (FULL, `out_ready=0`): both readies are 0. `out_gray`/`out_id` stay stable and arbitration state is frozen.
- `rst` mid-operation: an in-flight output is dropped with no completion; the next cycle sees reset values.

**Reset values**
- `out_valid=0`, `out_gray=0`, `out_id=0`.
- `grant_cnt0=0`, `grant_cnt1=0`.
- `last_grant=1`, so req0 wins the first contended cycle.
- `req0_ready`/`req1_ready` follow combinationally: whichever requester is granted may be accepted in the first cycle after reset.

## Timing

- Latency is one cycle: a request accepted at edge k appears on `out_*` after edge k.
- Full throughput: one transfer per cycle while `out_ready=1`.
- Fairness under continuous contention is strict alternation 0,1,0,1,…. Each requester waits at most one accepted transfer of the other.
- `reqN_ready` depends combinationally on `reqN_valid` (both), `out_valid` and `out_ready`. There is no combinational path from `reqN_bin` to any output.
- `out_*` and the counters are driven directly from flops.

## Structure

**Shared package `gray_pkg`**
- `localparam GW = 4` (code width).
- Requester-id constants `ID_REQ0 = 1'b0`, `ID_REQ1 = 1'b1`.

**Sub-module**
- One instance of the existing `binary_to_gray` (ports `b[3:0]`, `g[3:0]`), fed by the granted requester's code through a 2:1 mux.
- Arbiter, output register and counters are local to `gray_conv_arbiter`.

## Test plan

1. **Reset.** Assert `rst` 2 cycles with both requesters valid -> while `rst` is high the output register and counters stay at reset values (`out_valid=0`, `out_gray=0`, `grant_cnt0/1=0`). On the first cycle after `rst` falls, `req0_ready=1` and `req1_ready=0`.
2. **Single requester.** req0 offers `4'b1011`, `out_ready=1` -> next cycle `out_valid=1`, `out_gray=4'b1110`, `out_id=0`, `grant_cnt0=1`.
3. **Contention.** Both valid continuously (req0 `4'b0101`, req1 `4'b1111`), `out_ready=1` -> outputs alternate `4'b0111`/id0 and `4'b1000`/id1 every cycle, with no bubbles.
4. **Backpressure.** Output FULL with `4'b0100`/id1, `out_ready=0` for 3 cycles while req0 offers `4'b1000` -> both readies are 0 and the output holds. When `out_ready` rises, the same cycle sees `req0_ready=1`, and the next cycle shows `4'b1100`/id0.
5. **Counter wrap.** CW=2, 5 req1 transfers -> `grant_cnt1` reads 1,2,3,0,1; `grant_cnt0` stays 0.
6. **Reset mid-operation.** Assert `rst` while `out_valid=1`, `out_ready=0` -> next cycle `out_valid=0` and the counters are cleared. After release, req0 wins first even if req0 was the last grant before reset.
